// File: rtl/deserializer.sv
// deserializer
//   Collects an MSB-first serial bit stream into DATA_W-bit parallel words.
//   One word is emitted per DATA_W accepted bits, flagged by a single-cycle
//   strobe. Cycles with data_val_i low are skipped, so gaps in the input
//   stream are harmless.
//
//   Optional feature (macro DESERIALIZER_TIMEOUT_FLUSH_EN): once a partial
//   word has been idle for TIMEOUT_CYCLES cycles, it is flushed. The flushed
//   word is left-aligned and reports its bit count on deser_data_mod_o.
//   Without the macro, partial bits wait indefinitely and deser_data_mod_o
//   is tied to 0.
//
// Handshake: data_i is taken on every clk_i edge where data_val_i is high.
//   The input has no ready signal. The output has no backpressure either:
//   deser_data_val_o is high for exactly one cycle per word, and
//   deser_data_o / deser_data_mod_o then hold until the next strobe.
//
// Ports
//   clk_i             in   clock
//   srst_i            in   synchronous reset, active-high
//   data_i            in   serial data bit
//   data_val_i        in   data_i valid this cycle
//   deser_data_o      out  assembled word, first received bit at [DATA_W-1]
//   deser_data_mod_o  out  valid bit count of deser_data_o, 0 = full word
//   deser_data_val_o  out  one-cycle strobe qualifying the two outputs above

module deserializer #(
    parameter int DATA_W         = 16,
    parameter int DATA_MOD_W     = 4,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  data_i,
    input  logic                  data_val_i,
    output logic [DATA_W-1:0]     deser_data_o,
    output logic [DATA_MOD_W-1:0] deser_data_mod_o,
    output logic                  deser_data_val_o
);

    // The bit counter is one bit wider than the mod field.
    // Because of that, DATA_W itself can be represented.
    localparam int CNT_W = DATA_MOD_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    if (TIMEOUT_CYCLES < 1 || DATA_W < 2 || DATA_W > (1 << DATA_MOD_W)) begin : g_bad_params
        $error("deserializer: illegal parameter combination");
    end

    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift_next;
    logic              word_done;
    logic              flush_fire;
    logic [DATA_W-1:0] flush_word;

    assign shift_next = {shift_reg[DATA_W-2:0], data_i};
    assign word_done  = data_val_i && (cnt == LAST_BIT);

`ifdef DESERIALIZER_TIMEOUT_FLUSH_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DATA_W_C  = CNT_W'(DATA_W);

    logic [IDLE_W-1:0]     idle_cnt;
    logic [DATA_MOD_W-1:0] mod_q;

    // The flush decision is made on the edge that would count the final idle
    // cycle. If a bit is accepted on that same edge, data_val_i is high and
    // the flush is suppressed.
    assign flush_fire = !data_val_i && (cnt != '0) && (idle_cnt == IDLE_LAST);

    // The partial bits sit in the low cnt positions of shift_reg.
    // Shifting them up left-aligns them, and the LSBs are zero-filled.
    assign flush_word = shift_reg << (DATA_W_C - cnt);

    always_ff @(posedge clk_i) begin
        if (srst_i || data_val_i || (cnt == '0) || flush_fire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            mod_q <= '0;
        end else if (word_done) begin
            mod_q <= '0;
        end else if (flush_fire) begin
            mod_q <= cnt[DATA_MOD_W-1:0];
        end
    end

    assign deser_data_mod_o = mod_q;
`else
    assign flush_fire       = 1'b0;
    assign flush_word       = '0;
    assign deser_data_mod_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shift_reg        <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= word_done || flush_fire;

            if (data_val_i) begin
                shift_reg <= shift_next;
                cnt       <= word_done ? '0 : cnt + CNT_W'(1);
            end else if (flush_fire) begin
                shift_reg <= '0;
                cnt       <= '0;
            end

            if (word_done) begin
                deser_data_o <= shift_next;
            end else if (flush_fire) begin
                deser_data_o <= flush_word;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [15:0] pulse_data_q[$];
  logic [3:0]  pulse_mod_q[$];
  int          pulse_cyc_q[$];

  deserializer #(
    .DATA_W(16),
    .DATA_MOD_W(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i),
    .srst_i(srst_i),
    .data_i(data_i),
    .data_val_i(data_val_i),
    .deser_data_o(deser_data_o),
    .deser_data_mod_o(deser_data_mod_o),
    .deser_data_val_o(deser_data_val_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // Pulse monitor: sampled 2 time units after each rising edge.
  // cyc holds the index of the edge that produced the sample.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #2;
    if (deser_data_val_o === 1'b1) begin
      pulse_data_q.push_back(deser_data_o);
      pulse_mod_q.push_back(deser_data_mod_o);
      pulse_cyc_q.push_back(cyc);
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic drive_bit(input logic b);
    @(negedge clk_i);
    data_i = b;
    data_val_i = 1'b1;
    last_cyc = cyc + 1;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      data_i = 1'b0;
      data_val_i = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    for (int i = 15; i >= 0; i--) begin
      drive_bit(w[i]);
      if (gaps) drive_idle(1);
    end
  endtask

  task automatic clear_mon();
    pulse_data_q.delete();
    pulse_mod_q.delete();
    pulse_cyc_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    srst_i = 1'b1;
    data_val_i = 1'b0;
    @(negedge clk_i);
    srst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    srst_i = 1'b1;
    data_val_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (deser_data_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0000", deser_data_o);
    end
    checks++;
    if (deser_data_mod_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_mod: got %h expected 0", deser_data_mod_o);
    end
    checks++;
    if (deser_data_val_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_val: got %b expected 0", deser_data_val_o);
    end
    srst_i = 1'b0;
  endtask

  task automatic test_full_word();
    int lc;
    clear_mon();
    send_word(16'hA5C3, 1'b0);
    lc = last_cyc;
    drive_idle(4);
    checks++;
    if (pulse_data_q.size() !== 1) begin
      errors++;
      $display("FAIL full_count: got %0d pulses expected 1", pulse_data_q.size());
    end else begin
      checks++;
      if (pulse_data_q[0] !== 16'hA5C3) begin
        errors++;
        $display("FAIL full_data: got %h expected a5c3", pulse_data_q[0]);
      end
      checks++;
      if (pulse_mod_q[0] !== 4'h0) begin
        errors++;
        $display("FAIL full_mod: got %h expected 0", pulse_mod_q[0]);
      end
      checks++;
      if (pulse_cyc_q[0] !== lc) begin
        errors++;
        $display("FAIL full_latency: pulse at edge %0d expected edge %0d", pulse_cyc_q[0], lc);
      end
    end
    checks++;
    if (deser_data_o !== 16'hA5C3 || deser_data_val_o !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: got data %h val %b expected a5c3 0", deser_data_o, deser_data_val_o);
    end
  endtask

  task automatic test_gaps();
    clear_mon();
    send_word(16'hBEEF, 1'b1);
    drive_idle(4);
    checks++;
    if (pulse_data_q.size() !== 1) begin
      errors++;
      $display("FAIL gaps_count: got %0d pulses expected 1", pulse_data_q.size());
    end else begin
      checks++;
      if (pulse_data_q[0] !== 16'hBEEF) begin
        errors++;
        $display("FAIL gaps_data: got %h expected beef", pulse_data_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_word(16'h1234, 1'b0);
    send_word(16'h5678, 1'b0);
    drive_idle(4);
    checks++;
    if (pulse_data_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses expected 2", pulse_data_q.size());
    end else begin
      checks++;
      if (pulse_data_q[0] !== 16'h1234) begin
        errors++;
        $display("FAIL b2b_first: got %h expected 1234", pulse_data_q[0]);
      end
      checks++;
      if (pulse_data_q[1] !== 16'h5678) begin
        errors++;
        $display("FAIL b2b_second: got %h expected 5678", pulse_data_q[1]);
      end
      checks++;
      if (pulse_cyc_q[1] - pulse_cyc_q[0] !== 16) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d clks expected 16", pulse_cyc_q[1] - pulse_cyc_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    clear_mon();
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(negedge clk_i);
    srst_i = 1'b1;
    data_val_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (deser_data_o !== 16'h0000 || deser_data_val_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got data %h val %b expected 0000 0", deser_data_o, deser_data_val_o);
    end
    srst_i = 1'b0;
    send_word(16'hFFFF, 1'b0);
    drive_idle(4);
    checks++;
    if (pulse_data_q.size() !== 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d pulses expected 1", pulse_data_q.size());
    end else begin
      checks++;
      if (pulse_data_q[0] !== 16'hFFFF) begin
        errors++;
        $display("FAIL midrst_data: got %h expected ffff", pulse_data_q[0]);
      end
    end
  endtask

  task automatic test_flush();
    int lc;
    clear_mon();
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    lc = last_cyc;
`ifdef DESERIALIZER_TIMEOUT_FLUSH_EN
    drive_idle(12);
    checks++;
    if (pulse_data_q.size() !== 1) begin
      errors++;
      $display("FAIL flush_count: got %0d pulses expected 1", pulse_data_q.size());
    end else begin
      checks++;
      if (pulse_data_q[0] !== 16'hA000) begin
        errors++;
        $display("FAIL flush_data: got %h expected a000", pulse_data_q[0]);
      end
      checks++;
      if (pulse_mod_q[0] !== 4'd3) begin
        errors++;
        $display("FAIL flush_mod: got %0d expected 3", pulse_mod_q[0]);
      end
      checks++;
      if (pulse_cyc_q[0] !== lc + 8) begin
        errors++;
        $display("FAIL flush_timing: pulse at edge %0d expected edge %0d", pulse_cyc_q[0], lc + 8);
      end
    end
`else
    drive_idle(20);
    checks++;
    if (pulse_data_q.size() !== 0) begin
      errors++;
      $display("FAIL noflush_count: got %0d pulses expected 0 (last bit at edge %0d)", pulse_data_q.size(), lc);
    end
    apply_reset();
`endif
  endtask

  task automatic test_accept_on_expiry();
    clear_mon();
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    drive_idle(7);
    // This bit lands on the eighth idle cycle, the one that would expire.
    drive_bit(1'b1);
    drive_idle(2);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    drive_idle(4);
    checks++;
    if (pulse_data_q.size() !== 1) begin
      errors++;
      $display("FAIL expiry_count: got %0d pulses expected 1", pulse_data_q.size());
    end else begin
      checks++;
      if (pulse_data_q[0] !== 16'hB234) begin
        errors++;
        $display("FAIL expiry_data: got %h expected b234", pulse_data_q[0]);
      end
      checks++;
      if (pulse_mod_q[0] !== 4'h0) begin
        errors++;
        $display("FAIL expiry_mod: got %h expected 0", pulse_mod_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_gaps();
    test_back_to_back();
    test_reset_mid_word();
    test_flush();
    test_accept_on_expiry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
